// File: rtl/imem_loader.sv
// Boot-time instruction loader: assembles a big-endian byte stream into words, writes them
// to instruction memory and holds the core until the trailing XOR checksum has matched.
module imem_loader #(
    parameter int          ADDR_WIDTH = 7,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  cpu_run
);
    localparam logic [31:0]         MAX_WORDS = 32'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE_W     = (ADDR_WIDTH+1)'(1);

    localparam logic [2:0] S_HDR   = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [31:0]           checksum_q, checksum_d;
    logic                  imem_we_q, imem_we_d;
    logic [31:0]           imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  fire, word_done;
    logic [31:0]           word;
    logic [ADDR_WIDTH:0]   index_inc;

    // Ready depends on registered state only, so upstream never sees a combinational loop.
    assign in_ready  = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHECK);
    assign fire      = in_valid && in_ready;
    assign word_done = fire && (byte_cnt_q == 2'd3);
    assign word      = {shift_q, in_data};
    assign index_inc = {1'b0, index_q} + ONE_W;

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        shift_d        = shift_q;
        index_d        = index_q;
        count_d        = count_q;
        checksum_d     = checksum_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        words_loaded_d = words_loaded_q;
        done_d         = done_q;
        error_d        = error_q;

        if (fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], in_data};
        end

        if (word_done) begin
            case (state_q)
                S_HDR: begin
                    count_d = word[ADDR_WIDTH:0];
                    if (word > MAX_WORDS) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (word == 32'h0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    imem_we_d      = 1'b1;
                    imem_addr_d    = BASE_ADDR + {{(30-ADDR_WIDTH){1'b0}}, index_q, 2'b00};
                    imem_wdata_d   = word;
                    words_loaded_d = words_loaded_q + ONE_W;
                    checksum_d     = checksum_q ^ word;
                    index_d        = index_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    if (index_inc == count_q) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (word == checksum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_HDR;
            byte_cnt_q     <= 2'd0;
            shift_q        <= 24'h0;
            index_q        <= '0;
            count_q        <= '0;
            checksum_q     <= 32'h0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE_ADDR;
            imem_wdata_q   <= 32'h0;
            words_loaded_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            shift_q        <= shift_d;
            index_q        <= index_d;
            count_q        <= count_d;
            checksum_q     <= checksum_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            words_loaded_q <= words_loaded_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign words_loaded = words_loaded_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign cpu_run      = done_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are streamed and
// retired by a monitor on each imem_we pulse.
module tb_imem_loader;
    localparam int          AW   = 7;
    localparam logic [31:0] BASE = 32'h0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    in_data = 8'h0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words_loaded;
    logic          load_done;
    logic          load_error;
    logic          cpu_run;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .words_loaded(words_loaded), .load_done(load_done),
        .load_error(load_error), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          wl_exp = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] img[0:127];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Retire one expected write per strobe; a strobe with nothing queued is a fault.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", imem_addr, mon_e.addr);
                chk("wr_data", imem_wdata, mon_e.data);
                wl_exp++;
                chk("words_loaded", 32'(words_loaded), 32'(wl_exp));
            end
            last_addr = imem_addr;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        wl_exp   = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_error", 32'(load_error), 32'd0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) while ($urandom_range(1, 0) == 1) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic send_image(input int n, input logic [31:0] cks, input bit gaps);
        wr_t e;
        send_word(32'(n), gaps);
        for (int i = 0; i < n; i++) begin
            e.addr = BASE + 32'(4 * i);
            e.data = img[i];
            exp_q.push_back(e);
            send_word(img[i], gaps);
        end
        send_word(cks, gaps);
    endtask

    task automatic end_check(input string tag, input bit exp_done, input int exp_words);
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
        chk({tag, "_error"}, 32'(load_error), 32'(!exp_done));
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(exp_done));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] xor_img(input int n);
        logic [31:0] x = 32'h0;
        for (int i = 0; i < n; i++) x ^= img[i];
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Image 1: good checksum
        img[0] = 32'h20080005;
        img[1] = 32'h20090003;
        do_reset();
        send_image(2, xor_img(2), 1'b0);
        end_check("img1", 1'b1, 2);
        chk("img1_last_addr", last_addr, BASE + 32'h4);
        // Bytes offered while done must be ignored
        in_data = 8'hAA; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("absorb_done", 32'(load_done), 32'd1);
        chk("absorb_words", 32'(words_loaded), 32'd2);

        // Image 1 with a bad checksum
        do_reset();
        send_image(2, 32'h00000000, 1'b0);
        end_check("badcks", 1'b0, 2);

        // Oversized header: error right after its last byte, no writes
        do_reset();
        send_word(32'd129, 1'b0);
        chk("hdr129_error", 32'(load_error), 32'd1);
        end_check("hdr129", 1'b0, 0);

        // Empty image
        do_reset();
        send_image(0, 32'h0, 1'b0);
        end_check("n0", 1'b1, 0);

        // Full-capacity image
        do_reset();
        for (int i = 0; i < 128; i++) img[i] = $urandom;
        send_image(128, xor_img(128), 1'b0);
        end_check("n128", 1'b1, 128);
        chk("n128_last_addr", last_addr, BASE + 32'h1FC);

        // Image 1 with random valid gaps
        img[0] = 32'h20080005;
        img[1] = 32'h20090003;
        do_reset();
        send_image(2, xor_img(2), 1'b1);
        end_check("gaps", 1'b1, 2);

        // Reset mid-load after 6 payload bytes, then reload
        do_reset();
        send_word(32'd2, 1'b0);
        begin
            wr_t e;
            e.addr = BASE;
            e.data = img[0];
            exp_q.push_back(e);
        end
        send_word(img[0], 1'b0);
        send_byte(img[1][31:24], 1'b0);
        send_byte(img[1][23:16], 1'b0);
        do_reset();
        send_image(2, xor_img(2), 1'b0);
        end_check("reload", 1'b1, 2);
        chk("reload_last_addr", last_addr, BASE + 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
